// File: rtl/y86_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : y86_imem_loader
//  Description : Byte-serial program loader and 10-byte-wide instruction fetch
//                port for a Y86 pipeline. A small FSM (IDLE/LOAD/RUN/ERR)
//                gates loader writes and pipeline fetches so that they never
//                overlap in time.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_imem_loader #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [63:0] f_pc,
  output logic [79:0] f_Byte,
  output logic        imem_error,
  output logic        cpu_run,
  output logic [15:0] ld_count,
  output logic        ld_err
);

  localparam int          AW      = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 10);
  localparam logic [15:0] FULL    = 16'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic          err_q,   err_d;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_base;
  logic [7:0]    mem_q [MEM_BYTES];

  // Control state; reset takes effect immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Next-state, loader handshake and write strobe.
  // A restart (ld_start) in LOAD takes priority over a byte offered in the
  // same cycle; that byte is not written.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    ld_ready = 1'b0;
    cpu_run  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          count_d = '0;
        end else if (ld_valid) begin
          if (count_q == FULL) begin
            // Memory full: discard the byte and latch the overflow.
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + 16'd1;
            if (ld_last) begin
              state_d = S_RUN;
            end
          end
        end
      end
      S_RUN: begin
        cpu_run = 1'b1;
        if (ld_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_ERR: begin
        // Terminal until reset.
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign wr_addr  = count_q[AW-1:0];
  assign rd_base  = f_pc[AW-1:0];
  assign ld_count = count_q;
  assign ld_err   = err_q;

  // Program storage; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= ld_data;
    end
  end

  // Ten-byte little-endian fetch window, only live while running.
  always_comb begin
    f_Byte     = '0;
    imem_error = 1'b0;
    if (cpu_run) begin
      if (f_pc > LAST_PC) begin
        imem_error = 1'b1;
      end else begin
        for (int k = 0; k < 10; k++) begin
          f_Byte[8*k +: 8] = mem_q[rd_base + AW'(k)];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y86_imem_loader
//  Description : Self-checking bench for y86_imem_loader with a behavioural
//                reference model and randomized loader / fetch stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_imem_loader;

  localparam int MB = 16;
  localparam int ST_IDLE = 0, ST_LOAD = 1, ST_RUN = 2, ST_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready, imem_error, cpu_run, ld_err;
  logic [63:0] f_pc = 64'd0;
  logic [79:0] f_Byte;
  logic [15:0] ld_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_state = ST_IDLE;
  int         m_count = 0;
  bit         m_err   = 1'b0;
  logic [7:0] m_mem [MB];

  y86_imem_loader #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .f_pc(f_pc),
    .f_Byte(f_Byte), .imem_error(imem_error), .cpu_run(cpu_run),
    .ld_count(ld_count), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  // One rising edge of the loader's behaviour, from the rules of the block.
  task automatic model_edge();
    if (m_state == ST_IDLE) begin
      if (ld_start) begin m_state = ST_LOAD; m_count = 0; end
    end else if (m_state == ST_LOAD) begin
      if (ld_start) m_count = 0;
      else if (ld_valid) begin
        if (m_count == MB) begin m_state = ST_ERR; m_err = 1'b1; end
        else begin
          m_mem[m_count] = ld_data;
          m_count++;
          if (ld_last) m_state = ST_RUN;
        end
      end
    end else if (m_state == ST_RUN) begin
      if (ld_start) begin m_state = ST_LOAD; m_count = 0; end
    end
  endtask

  function automatic logic [79:0] exp_fbyte();
    logic [79:0] r = '0;
    if (m_state == ST_RUN && f_pc <= 64'(MB - 10))
      for (int k = 0; k < 10; k++) r[8*k +: 8] = m_mem[int'(f_pc) + k];
    return r;
  endfunction

  task automatic check_all();
    chk("ld_ready",   {79'd0, ld_ready},   {79'd0, m_state == ST_LOAD});
    chk("cpu_run",    {79'd0, cpu_run},    {79'd0, m_state == ST_RUN});
    chk("ld_count",   {64'd0, ld_count},   80'(m_count));
    chk("ld_err",     {79'd0, ld_err},     {79'd0, m_err});
    chk("imem_error", {79'd0, imem_error},
        {79'd0, (m_state == ST_RUN) && (f_pc > 64'(MB - 10))});
    chk("f_Byte",     f_Byte,              exp_fbyte());
  endtask

  function automatic logic [63:0] rand_pc();
    case ($urandom_range(3))
      0, 1: return 64'($urandom_range(MB - 10));
      2:    return 64'($urandom_range(MB + 4, MB - 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Drive inputs, take one clock edge, check at the following falling edge.
  task automatic drive(bit s, bit v, logic [7:0] d, bit l);
    ld_start = s; ld_valid = v; ld_data = d; ld_last = l;
    f_pc = rand_pc();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(logic [7:0] d, bit l, int stall_pct);
    while (int'($urandom_range(99)) < stall_pct)
      drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
    drive(1'b0, 1'b1, d, l);
  endtask

  task automatic rand_load(int n, int stall_pct);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < n; i++) send(8'($urandom), i == n - 1, stall_pct);
  endtask

  initial begin
    logic [7:0] prog [11];
    prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Fill the whole memory once so every fetch window has a known value
    rand_load(MB, 20);
    chk("fill_count", {64'd0, ld_count}, 80'd16);
    chk("fill_run",   {79'd0, cpu_run},  80'd1);
    repeat (10) drive(1'b0, 1'b1, 8'($urandom), 1'($urandom)); // ignored in RUN

    // Reference program load
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 11; i++) send(prog[i], i == 10, 0);
    chk("prog_count", {64'd0, ld_count}, 80'd11);
    chk("prog_run",   {79'd0, cpu_run},  80'd1);
    f_pc = 64'd0; #1;
    chk("prog_fbyte", f_Byte, 80'h000000000000000AF230);
    chk("prog_ierr",  {79'd0, imem_error}, 80'd0);

    // Fetch range boundaries
    f_pc = 64'(MB - 10); #1;
    chk("pc_max_ierr", {79'd0, imem_error}, 80'd0);
    check_all();
    f_pc = 64'(MB - 9); #1;
    chk("pc_over_ierr",  {79'd0, imem_error}, 80'd1);
    chk("pc_over_fbyte", f_Byte, 80'd0);
    f_pc = '1; #1;
    chk("pc_ones_ierr",  {79'd0, imem_error}, 80'd1);
    chk("pc_ones_fbyte", f_Byte, 80'd0);
    repeat (20) drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Reload from RUN with a 5-cycle loader stall mid-load
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reload_run",   {79'd0, cpu_run},  80'd0);
    chk("reload_count", {64'd0, ld_count}, 80'd0);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 0);
    repeat (5) drive(1'b0, 1'b0, 8'($urandom), 1'b1);
    chk("stall_count", {64'd0, ld_count}, 80'd3);
    for (int i = 3; i < 9; i++) send(8'($urandom), i == 8, 0);
    chk("stall_done", {64'd0, ld_count}, 80'd9);
    repeat (8) drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized loads, including restarts in the middle of a load
    for (int it = 0; it < 25; it++) begin
      int n = int'($urandom_range(1, MB));
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(15) == 0) drive(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'($urandom), i == n - 1, 30);
      end
      repeat (int'($urandom_range(1, 12))) drive(1'b0, 1'b0, 8'h00, 1'b0);
    end

    // Asynchronous reset in the middle of a load
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 0);
    ld_valid = 1'b0;
    @(posedge clk);
    model_edge();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_count", {64'd0, ld_count}, 80'd0);
    chk("arst_ready", {79'd0, ld_ready}, 80'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    chk("arst_start", {79'd0, ld_ready}, 80'd1);
    send(8'($urandom), 1'b0, 0);
    send(8'($urandom), 1'b1, 0);
    chk("arst_count2", {64'd0, ld_count}, 80'd2);
    chk("arst_run",    {79'd0, cpu_run},  80'd1);

    // Overflow: 17 bytes with no last marker
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < MB + 1; i++) send(8'($urandom), 1'b0, 10);
    chk("ovf_count", {64'd0, ld_count}, 80'd16);
    chk("ovf_err",   {79'd0, ld_err},   80'd1);
    chk("ovf_run",   {79'd0, cpu_run},  80'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h55, 1'b1);
    chk("err_hold_ready", {79'd0, ld_ready}, 80'd0);
    chk("err_hold_count", {64'd0, ld_count}, 80'd16);
    chk("err_hold_err",   {79'd0, ld_err},   80'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y86_imem_loader.md
Y86_IMEM_LOADER -- requirements
Module: y86_imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning instruction memory size in bytes (power of two, >= 16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ld_start  input  1  one-cycle pulse that begins a program load.
REQ-005 SHALL have port ld_valid  input  1  loader byte valid.
REQ-006 SHALL have port ld_data  input  8  program byte.
REQ-007 SHALL have port ld_last  input  1  marks the final byte of the program; qualified by ld_valid.
REQ-008 SHALL have port ld_ready  output  1  loader may transfer a byte this cycle.
REQ-009 SHALL have port f_pc  input  64  fetch address from the pipeline F stage.
REQ-010 SHALL have port f_Byte  output  80  ten instruction bytes starting at f_pc.
REQ-011 SHALL have port imem_error  output  1  fetch address out of range.
REQ-012 SHALL have port cpu_run  output  1  pipeline enable; high only in RUN.
REQ-013 SHALL have port ld_count  output  16  number of bytes accepted in the current or last load.
REQ-014 SHALL have port ld_err  output  1  sticky overflow flag.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, ERR; encoding free.
REQ-016 IDLE: ld_start -> LOAD; ld_count cleared to 0 on the same edge.
REQ-017 LOAD: ld_ready=1; a byte transfers on a rising edge where ld_valid && ld_ready; it is written to address ld_count, and ld_count increments by 1.
REQ-018 LOAD: a transfer with ld_last=1 -> RUN on that edge, byte written, count incremented.
REQ-019 LOAD: a transfer when ld_count == MEM_BYTES (memory full) -> ERR; byte discarded; ld_err set.
REQ-020 ld_ready SHALL be 0 in IDLE, RUN and ERR; ld_valid outside LOAD is ignored.
REQ-021 RUN: cpu_run=1; ld_start -> LOAD (reload), cpu_run drops on that edge.
REQ-022 ERR: held until rst; ld_start ignored; cpu_run=0.
REQ-023 ld_start in LOAD SHALL restart the load: ld_count=0, previously written bytes remain but are overwritten by the new load.
REQ-024 f_Byte SHALL be combinational from f_pc: byte at address f_pc+k drives f_Byte[8k+7:8k], k=0..9 (byte at f_pc in bits [7:0]).
REQ-025 imem_error=1 when f_pc > MEM_BYTES-10 (unsigned 64-bit compare, no wrap); f_Byte=0 in that case.
REQ-026 f_Byte SHALL be 0 and imem_error 0 whenever cpu_run=0.
REQ-027 Memory writes and fetch reads in the same cycle cannot conflict (fetch only in RUN, writes only in LOAD).
REQ-028 ld_count SHALL saturate at MEM_BYTES, never wrap.

Reset
REQ-029 rst asserted SHALL immediately force state IDLE, ld_ready=0, cpu_run=0, ld_count=0, ld_err=0, f_Byte=0, imem_error=0, regardless of clk.
REQ-030 Memory contents SHALL NOT be cleared by reset; reset mid-LOAD abandons the load with no further writes.
REQ-031 After rst deasserts, the first ld_start is accepted on the next rising edge.

Verification
REQ-032 Load bytes 0x30,0xF2,0x0A,0,0,0,0,0,0,0,0x00 (last on 11th) -> ld_count=11, cpu_run=1 next cycle; f_pc=0 -> f_Byte=0x000000000000000AF230 with imem_error=0.
REQ-033 Stall loader (ld_valid low 5 cycles mid-load) -> ld_count unchanged, no writes, resumes correctly.
REQ-034 MEM_BYTES=16, send 17 bytes without ld_last -> ld_count=16, ld_err=1, state ERR, cpu_run=0, ld_start ignored.
REQ-035 RUN, f_pc=MEM_BYTES-10 -> imem_error=0; f_pc=MEM_BYTES-9 and f_pc=0xFFFFFFFFFFFFFFFF -> imem_error=1, f_Byte=0.
REQ-036 Assert rst asynchronously mid-LOAD after 4 bytes -> outputs at reset values before next edge; new load of 2 bytes gives ld_count=2, RUN.
REQ-037 ld_start during RUN -> cpu_run=0 next edge, ld_count=0, f_Byte=0 until the new load completes.
